// File: rtl/ckrs_pkg.sv
// Clock/reset bundle shared by frame-clock-domain blocks.
package CKRSPkg;

    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

endpackage

// File: rtl/gbt_pattern_checker_pkg.sv
// Shared types and defaults for the GBT motor-data pattern checker.
package GbtChkPkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } t_chk_state;

    localparam int PATTERN_W        = 32;
    localparam int LOCK_FRAMES_DFLT = 16;
    localparam int UNLOCK_ERRS_DFLT = 4;

endpackage

// File: rtl/gbt_pattern_checker_sat_counter.sv
// Saturating event counter; a coincident clear and increment loads 1.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? W'(1) : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/gbt_pattern_checker.sv
// Lock/track checker for the {cnt, cnt} GBT test pattern with link statistics.
module gbt_pattern_checker
    import GbtChkPkg::*;
    import CKRSPkg::*;
#(
    parameter int LOCK_FRAMES = LOCK_FRAMES_DFLT,
    parameter int UNLOCK_ERRS = UNLOCK_ERRS_DFLT,
    parameter int CNT_W       = 32
) (
    input  ckrs_t                ClkRs_ix,
    input  logic                 rx_valid_i,
    input  logic [63:0]          rx_data_b64_i,
    input  logic                 clear_i,
    output logic                 locked_o,
    output logic                 error_o,
    output logic [CNT_W-1:0]     frame_cnt_o,
    output logic [CNT_W-1:0]     err_cnt_o,
    output logic [CNT_W-1:0]     lock_loss_cnt_o,
    output logic [PATTERN_W-1:0] expected_o
);

    localparam logic [8:0] LOCK_N   = 9'(LOCK_FRAMES);
    localparam logic [8:0] UNLOCK_N = 9'(UNLOCK_ERRS);

    logic                 clk;
    logic                 rst;
    t_chk_state           state_q;
    logic [PATTERN_W-1:0] expected_q;
    logic [7:0]           match_q;
    logic [7:0]           bad_run_q;
    logic                 locked_q;
    logic                 error_q;

    logic [PATTERN_W-1:0] w;
    logic                 consistent;
    logic                 good;
    logic                 in_lock;
    logic                 bad_lock;
    logic                 drop;
    logic [8:0]           match_nxt;
    logic [8:0]           bad_nxt;

    assign clk        = ClkRs_ix.clk;
    assign rst        = ClkRs_ix.reset;
    assign w          = rx_data_b64_i[31:0];
    assign consistent = (rx_data_b64_i[63:32] == w);
    assign good       = consistent && (w == expected_q);
    assign in_lock    = rx_valid_i && (state_q == LOCKED);
    assign bad_lock   = in_lock && !good;
    assign match_nxt  = {1'b0, match_q} + 9'd1;
    assign bad_nxt    = {1'b0, bad_run_q} + 9'd1;
    assign drop       = bad_lock && (bad_nxt == UNLOCK_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= UNLOCKED;
            expected_q <= '0;
            match_q    <= '0;
            bad_run_q  <= '0;
            locked_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            error_q <= 1'b0;
            if (rx_valid_i) begin
                unique case (state_q)
                    UNLOCKED: begin
                        if (consistent) begin
                            expected_q <= w + 32'd1;
                            match_q    <= 8'd1;
                            state_q    <= ACQUIRE;
                        end
                    end
                    ACQUIRE: begin
                        if (good) begin
                            match_q    <= match_nxt[7:0];
                            expected_q <= expected_q + 32'd1;
                            if (match_nxt == LOCK_N) begin
                                state_q   <= LOCKED;
                                locked_q  <= 1'b1;
                                bad_run_q <= '0;
                            end
                        end else if (consistent) begin
                            expected_q <= w + 32'd1;
                            match_q    <= 8'd1;
                        end else begin
                            state_q <= UNLOCKED;
                        end
                    end
                    LOCKED: begin
                        // Free-running so a single corrupt frame costs one error.
                        expected_q <= expected_q + 32'd1;
                        if (good) begin
                            bad_run_q <= '0;
                        end else begin
                            error_q <= 1'b1;
                            if (drop) begin
                                state_q   <= UNLOCKED;
                                locked_q  <= 1'b0;
                                bad_run_q <= '0;
                            end else begin
                                bad_run_q <= bad_nxt[7:0];
                            end
                        end
                    end
                    default: state_q <= UNLOCKED;
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (clear_i),
        .inc_i (in_lock),
        .cnt_o (frame_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (clear_i),
        .inc_i (bad_lock),
        .cnt_o (err_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_loss_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (clear_i),
        .inc_i (drop),
        .cnt_o (lock_loss_cnt_o)
    );

    assign locked_o   = locked_q;
    assign error_o    = error_q;
    assign expected_o = expected_q;

endmodule

// File: tb/tb_gbt_pattern_checker.sv
// Scoreboard bench for gbt_pattern_checker against a behavioural pattern model.
module tb_gbt_pattern_checker;
    import GbtChkPkg::*;
    import CKRSPkg::*;

    localparam int  CNT_W   = 32;
    localparam longint SATV = (64'd1 << CNT_W) - 1;

    ckrs_t             ckrs;
    logic              rx_valid;
    logic [63:0]       rx_data;
    logic              clr;
    logic              locked;
    logic              err;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  loss_cnt;
    logic [31:0]       expected;

    gbt_pattern_checker #(
        .LOCK_FRAMES (LOCK_FRAMES_DFLT),
        .UNLOCK_ERRS (UNLOCK_ERRS_DFLT),
        .CNT_W       (CNT_W)
    ) dut (
        .ClkRs_ix        (ckrs),
        .rx_valid_i      (rx_valid),
        .rx_data_b64_i   (rx_data),
        .clear_i         (clr),
        .locked_o        (locked),
        .error_o         (err),
        .frame_cnt_o     (frame_cnt),
        .err_cnt_o       (err_cnt),
        .lock_loss_cnt_o (loss_cnt),
        .expected_o      (expected)
    );

    initial ckrs.clk = 1'b0;
    always #5 ckrs.clk = ~ckrs.clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge ckrs.clk) cyc <= cyc + 1;

    typedef struct {
        bit          locked;
        bit          err;
        longint      fc;
        longint      ec;
        longint      lc;
        logic [31:0] exp;
        int          due;
    } exp_t;

    exp_t sb[$];

    // Reference model: mode 0 searching, 1 acquiring, 2 locked.
    int          m_mode;
    logic [31:0] m_exp;
    int          m_match;
    int          m_bad;
    longint      m_fc, m_ec, m_lc;

    function automatic longint sat_add(longint v);
        return (v >= SATV) ? SATV : v + 1;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [63:0] d,
                              input bit c, output exp_t e);
        logic [31:0] w;
        bit cons, good, e_err;
        e_err = 0;
        if (r) begin
            m_mode = 0; m_exp = 0; m_match = 0; m_bad = 0;
            m_fc = 0; m_ec = 0; m_lc = 0;
        end else begin
            if (c) begin m_fc = 0; m_ec = 0; m_lc = 0; end
            if (v) begin
                w    = d[31:0];
                cons = (d[63:32] == w);
                good = cons && (w == m_exp);
                if (m_mode == 0) begin
                    if (cons) begin m_exp = w + 1; m_match = 1; m_mode = 1; end
                end else if (m_mode == 1) begin
                    if (good) begin
                        m_match++; m_exp = m_exp + 1;
                        if (m_match == LOCK_FRAMES_DFLT) begin m_mode = 2; m_bad = 0; end
                    end else if (cons) begin
                        m_exp = w + 1; m_match = 1;
                    end else begin
                        m_mode = 0;
                    end
                end else begin
                    m_fc  = sat_add(m_fc);
                    m_exp = m_exp + 1;
                    if (good) m_bad = 0;
                    else begin
                        e_err = 1; m_ec = sat_add(m_ec); m_bad++;
                        if (m_bad == UNLOCK_ERRS_DFLT) begin
                            m_mode = 0; m_lc = sat_add(m_lc); m_bad = 0;
                        end
                    end
                end
            end
        end
        e.locked = (m_mode == 2);
        e.err    = e_err;
        e.fc     = m_fc;
        e.ec     = m_ec;
        e.lc     = m_lc;
        e.exp    = m_exp;
        e.due    = 0;
    endtask

    task automatic drive(input bit r, input bit v, input logic [63:0] d, input bit c);
        exp_t e;
        @(posedge ckrs.clk);
        #1;
        ckrs.reset = r;
        rx_valid   = v;
        rx_data    = d;
        clr        = c;
        model_step(r, v, d, c, e);
        e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic frame(input logic [31:0] c);
        drive(0, 1, {c, c}, 0);
    endtask

    task automatic idle(input int n, input bit c = 0);
        for (int i = 0; i < n; i++) drive(0, 0, {$urandom, $urandom}, c);
    endtask

    always @(negedge ckrs.clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("locked_o", locked, e.locked);
            chk("error_o", err, e.err);
            chk("frame_cnt_o", frame_cnt, e.fc);
            chk("err_cnt_o", err_cnt, e.ec);
            chk("lock_loss_cnt_o", loss_cnt, e.lc);
            chk("expected_o", expected, e.exp);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tx;
        int r;
        ckrs.reset = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = '0;
        clr        = 1'b0;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        idle(1);
        @(negedge ckrs.clk);
        chk("reset_locked", locked, 0);
        chk("reset_expected", expected, 0);

        // Acquire from 0x100.
        for (int i = 0; i < 15; i++) frame(32'h100 + i);
        idle(1);
        @(negedge ckrs.clk);
        chk("acq_not_locked_15", locked, 0);
        for (int i = 15; i < 20; i++) frame(32'h100 + i);
        idle(1);
        @(negedge ckrs.clk);
        chk("acq_locked", locked, 1);
        chk("acq_expected", expected, 32'h114);
        chk("acq_err_cnt", err_cnt, 0);

        // Wrap across 0xFFFFFFFF with gaps.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) frame(32'hFFFF_FFE0 + i);
        idle(1, 1);
        for (int i = 0; i < 5; i++) begin
            tx = 32'hFFFF_FFFE + i;
            frame(tx);
            idle(3);
        end
        @(negedge ckrs.clk);
        chk("wrap_frame_cnt", frame_cnt, 5);
        chk("wrap_err_cnt", err_cnt, 0);
        chk("wrap_locked", locked, 1);

        // Single corrupt frame.
        idle(1, 1);
        frame(32'd3);
        frame(32'hDEAD);
        frame(32'd5);
        idle(1);
        @(negedge ckrs.clk);
        chk("corrupt_err_cnt", err_cnt, 1);
        chk("corrupt_locked", locked, 1);

        // Four inconsistent frames drop lock, then relock.
        idle(1, 1);
        for (int i = 0; i < 4; i++) drive(0, 1, {32'd7 + i, 32'd6 + i}, 0);
        idle(1);
        @(negedge ckrs.clk);
        chk("drop_err_cnt", err_cnt, 4);
        chk("drop_locked", locked, 0);
        chk("drop_loss_cnt", loss_cnt, 1);
        for (int i = 0; i < 16; i++) frame(32'h200 + i);
        idle(1);
        @(negedge ckrs.clk);
        chk("relock", locked, 1);

        // Reseed during acquisition.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) frame(32'h18 + i);
        for (int i = 0; i < 15; i++) frame(32'h80 + i);
        idle(1);
        @(negedge ckrs.clk);
        chk("reseed_not_yet", locked, 0);
        frame(32'h8F);
        idle(1);
        @(negedge ckrs.clk);
        chk("reseed_locked", locked, 1);
        chk("reseed_err_cnt", err_cnt, 0);

        // Clear coincident with a bad frame.
        drive(0, 1, {32'h1234, 32'h1234}, 1);
        idle(1);
        @(negedge ckrs.clk);
        chk("clr_err_cnt", err_cnt, 1);
        chk("clr_frame_cnt", frame_cnt, 1);
        chk("clr_loss_cnt", loss_cnt, 0);

        // Reset mid-acquire.
        for (int i = 0; i < 5; i++) frame(32'h300 + i);
        drive(1, 0, 0, 0);
        idle(1);
        @(negedge ckrs.clk);
        chk("rst_mid_locked", locked, 0);
        chk("rst_mid_expected", expected, 0);
        chk("rst_mid_frame_cnt", frame_cnt, 0);

        // Randomized traffic.
        tx = $urandom;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30) begin
                idle(1, ($urandom_range(0, 49) == 0));
            end else if (r < 88) begin
                frame(tx);
                tx = tx + 1;
            end else if (r < 92) begin
                frame($urandom);
                tx = tx + 1;
            end else if (r < 96) begin
                drive(0, 1, {$urandom, tx}, $urandom_range(0, 9) == 0);
                tx = tx + 1;
            end else if (r < 99) begin
                tx = $urandom;
            end else begin
                drive(1, 0, 0, 0);
            end
        end
        idle(1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge ckrs.clk);
        @(negedge ckrs.clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gbt_pattern_checker.md
Name: gbt_pattern_checker

Overview:
- Receive-side checker for the GBT motor-data test pattern. The transmit generator sends one counter value per frame, duplicated in both halves: motor_data_b64 = {cnt, cnt}, with cnt incrementing by 1.
- Sits on the received GBT data stream in the 40 MHz frame clock domain, downstream of gbt_xu5.
- Acquires lock to the pattern, then counts corrupted frames and lock losses for link verification in hardware and in the bench.

Parameters:
- LOCK_FRAMES, 16: consecutive correct frames needed to declare lock (range 2..255).
- UNLOCK_ERRS, 4: consecutive bad frames in LOCKED that drop lock (range 1..255).
- CNT_W, 32: width of the frame, error and lock-loss counters.

Ports:
- ClkRs_ix  input  ckrs_t (CKRSPkg)  frame clock bundle. One clock: ClkRs_ix.clk. Reset ClkRs_ix.reset is synchronous and active-high.
- rx_valid_i  input  1  received frame valid this cycle (link ready and frame strobe).
- rx_data_b64_i  input  64  motor_data_b64 field of the received frame.
- clear_i  input  1  synchronous clear of the statistics counters.
- locked_o  output  1  pattern lock status.
- error_o  output  1  one-cycle pulse per bad frame while LOCKED.
- frame_cnt_o  output  CNT_W  valid frames seen while LOCKED (saturating).
- err_cnt_o  output  CNT_W  bad frames seen while LOCKED (saturating).
- lock_loss_cnt_o  output  CNT_W  LOCKED->UNLOCKED transitions (saturating).
- expected_o  output  32  current expected counter value (debug).

Behaviour:
- Reset: state UNLOCKED; all outputs 0; internal match and bad-run counters 0. A reset mid-operation aborts everything immediately.
- Frames with rx_valid_i=0 are ignored: no state change and no expected increment. Gaps are legal.
- Definitions:
  - w = rx_data_b64_i[31:0].
  - consistent = (rx_data_b64_i[63:32] == w).
  - good = consistent && (w == expected).
- Increment rule: expected increments modulo 2^32, so 0xFFFFFFFF -> 0x00000000 is a correct successor.
- UNLOCKED:
  - consistent frame -> expected = w+1, match = 1, go ACQUIRE.
  - inconsistent frame -> stay.
- ACQUIRE:
  - good -> match++, expected++. When match reaches LOCK_FRAMES, go LOCKED, locked_o = 1.
  - not good, but consistent -> reseed: expected = w+1, match = 1.
  - inconsistent -> go UNLOCKED.
- LOCKED:
  - Every valid frame: frame_cnt++ and expected++ (free-running), so one corrupted frame costs exactly one error.
  - good -> bad_run = 0.
  - bad -> error_o = 1 for one cycle, err_cnt++, bad_run++.
  - If bad_run reaches UNLOCK_ERRS: go UNLOCKED, locked_o = 0, lock_loss_cnt++, bad_run = 0. That final error is still counted.
- Latency: all outputs are registered. Response appears on the cycle after the frame's rx_valid_i edge.
- Counters saturate at all-ones and never wrap.
- clear_i zeroes frame_cnt, err_cnt and lock_loss_cnt; it does not affect state, expected or locked_o.
- clear_i together with an increment: the counter loads 1 (clear, then count the coincident event).

Decomposition:
- Shared package GbtChkPkg holds:
  - checker state enum t_chk_state {UNLOCKED, ACQUIRE, LOCKED};
  - pattern word width constant PATTERN_W = 32;
  - default LOCK_FRAMES and UNLOCK_ERRS constants, reused by bench and top level.
- One natural sub-module: sat_counter (parameter W; inputs inc, clr; clr&&inc gives 1). Instantiated three times.
- The FSM, expected register and match/bad-run counters stay in gbt_pattern_checker.

Test Plan:
- Reset, then 20 consistent frames starting {0x100,0x100} -> locked_o rises 1 cycle after the 16th frame (0x10F); expected_o = 0x114 after the 20th; err_cnt_o = 0.
- Locked, stream crosses 0xFFFFFFFE..0x00000002 with rx_valid_i gaps of 3 cycles -> no error_o, locked_o stays 1, frame_cnt_o increments once per valid frame only.
- Locked, one frame replaced by {0xDEAD,0xDEAD} -> error_o pulses once, err_cnt_o = 1, the next correct frame is good, locked_o = 1.
- Locked, 4 consecutive frames with upper != lower -> err_cnt_o = 4, locked_o = 0 after the 4th, lock_loss_cnt_o = 1. Correct stream resumes -> relock after 16 frames.
- During ACQUIRE, jump the sequence from 0x20 to 0x80 -> reseed, lock after 16 frames counted from 0x80, err_cnt_o stays 0.
- Locked, clear_i asserted in the same cycle as a bad frame -> err_cnt_o = 1, frame_cnt_o = 1, lock_loss_cnt_o = 0. Separately, reset asserted mid-ACQUIRE -> all outputs 0 next cycle.
